// File: rtl/segmented_sub_pipe_pkg.sv
// Shared constants and types for the segmented subtractor pipeline.
//   W       full datapath width
//   SPLIT   carry-chain break between stage 1 and stage 2
//   LANE_W  dual-single lane width
//   HI_LSB  LSB of the dual-single high lane
package maf_pkg;
   localparam int W      = 56;
   localparam int SPLIT  = 28;
   localparam int LANE_W = 24;
   localparam int HI_LSB = 32;
   localparam int HI_W   = W - SPLIT;

   localparam logic [2:0] MODE_FULL = 3'b000;
   localparam logic [2:0] MODE_DUAL = 3'b001;
   localparam logic [2:0] MODE_M3   = 3'b010;

   // Stage-1 register contents: low segment result plus the raw high operands.
   typedef struct packed {
      logic [SPLIT-1:0] lo_sum;
      logic             c28;    // carry out of bit 27, feeds the full-width high segment
      logic             c24;    // carry out of bit 23, low-lane borrow in dual mode
      logic [HI_W-1:0]  a_hi;
      logic [HI_W-1:0]  b_hi;
      logic [2:0]       cont;
   } s1_t;

   function automatic logic is_full(input logic [2:0] c);
      return (c == MODE_FULL) || (c == MODE_M3);
   endfunction
endpackage

// File: rtl/segmented_sub_pipe_if.sv
// Operand/result bus of the segmented subtractor.
//   slave  : seen by the pipeline (consumes operands, produces results)
//   master : seen by the operand selector / consumer side
interface segmented_sub_pipe_if;
   import maf_pkg::*;
   logic         in_valid;
   logic         in_ready;
   logic [2:0]   cont;
   logic [W-1:0] op_0;
   logic [W-1:0] op_1;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] diff;
   logic [1:0]   neg;
   logic [1:0]   zero;
   logic [2:0]   out_cont;

   modport master (output in_valid, cont, op_0, op_1, out_ready,
                   input  in_ready, out_valid, diff, neg, zero, out_cont);
   modport slave  (input  in_valid, cont, op_0, op_1, out_ready,
                   output in_ready, out_valid, diff, neg, zero, out_cont);
endinterface

// File: rtl/segmented_sub_pipe_seg.sv
// sub_seg28: 28-bit a + ~b + cin segment.
//   a, b  : operands (b is inverted internally)
//   cin   : carry in (1 for a plain subtract)
//   sum   : 28-bit result
//   c24   : carry out of bit 23 (dual-lane low-lane tap)
//   cout  : carry out of bit 27
module sub_seg28
   import maf_pkg::*;
(
   input  logic [SPLIT-1:0] a,
   input  logic [SPLIT-1:0] b,
   input  logic             cin,
   output logic [SPLIT-1:0] sum,
   output logic             c24,
   output logic             cout
);
   localparam int TOP_W = SPLIT - LANE_W;

   logic [LANE_W:0] lo;
   logic [TOP_W:0]  hi;

   always_comb begin
      lo = {1'b0, a[LANE_W-1:0]} + {1'b0, ~b[LANE_W-1:0]} + {{LANE_W{1'b0}}, cin};
      hi = {1'b0, a[SPLIT-1:LANE_W]} + {1'b0, ~b[SPLIT-1:LANE_W]} + {{TOP_W{1'b0}}, lo[LANE_W]};
   end

   assign sum  = {hi[TOP_W-1:0], lo[LANE_W-1:0]};
   assign c24  = lo[LANE_W];
   assign cout = hi[TOP_W];
endmodule

// File: rtl/segmented_sub_pipe.sv
// segmented_sub_pipe: two-stage segmented subtractor, diff = op_0 - op_1.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : valid/ready operand input and result output (slave side)
// Modes 000/010 subtract at full width; 001 subtracts two independent 24-bit
// lanes; any other mode passes the token through with a zero result.
module segmented_sub_pipe
   import maf_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   segmented_sub_pipe_if.slave bus
);
   localparam int GAP_W = HI_LSB - SPLIT;   // bits [31:28] between the lanes
   localparam int MID_W = HI_LSB - LANE_W;  // bits [31:24] forced to 0 in dual mode

   logic             s1_valid, out_valid_q;
   logic             out_adv, s1_adv;
   s1_t              s1_q;
   logic [SPLIT-1:0] s1_sum;
   logic             s1_c24, s1_c28;
   logic [HI_W-1:0]  s2_a, s2_b, s2_sum;
   logic             s2_cin, s2_cout, s2_c24_unused;
   logic [W-1:0]     r_diff, diff_q;
   logic [1:0]       r_neg, r_zero, neg_q, zero_q;
   logic [2:0]       cont_q;

   assign out_adv      = !out_valid_q || bus.out_ready;
   assign s1_adv       = !s1_valid || out_adv;
   assign bus.in_ready = s1_adv;

   // ---- stage 1: low segment ----
   sub_seg28 u_s1 (
      .a(bus.op_0[SPLIT-1:0]), .b(bus.op_1[SPLIT-1:0]), .cin(1'b1),
      .sum(s1_sum), .c24(s1_c24), .cout(s1_c28)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_q     <= '0;
      end else if (s1_adv) begin
         s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            s1_q.lo_sum <= s1_sum;
            s1_q.c28    <= s1_c28;
            s1_q.c24    <= s1_c24;
            s1_q.a_hi   <= bus.op_0[W-1:SPLIT];
            s1_q.b_hi   <= bus.op_1[W-1:SPLIT];
            s1_q.cont   <= bus.cont;
         end
      end
   end

   // ---- stage 2: high segment ----
   // In dual mode the gap nibble of both operands is forced to all-ones:
   // F + ~F + 1 = 0x10, so exactly a carry of 1 reaches bit 32 and c28 is
   // never seen by the high lane.
   always_comb begin
      s2_a   = s1_q.a_hi;
      s2_b   = s1_q.b_hi;
      s2_cin = s1_q.c28;
      if (s1_q.cont == MODE_DUAL) begin
         s2_a[GAP_W-1:0] = '1;
         s2_b[GAP_W-1:0] = '1;
         s2_cin          = 1'b1;
      end
   end

   sub_seg28 u_s2 (
      .a(s2_a), .b(s2_b), .cin(s2_cin),
      .sum(s2_sum), .c24(s2_c24_unused), .cout(s2_cout)
   );

   always_comb begin
      r_diff = '0;
      r_neg  = '0;
      r_zero = '0;
      if (is_full(s1_q.cont)) begin
         r_diff    = {s2_sum, s1_q.lo_sum};
         r_neg[0]  = ~s2_cout;
         r_zero[0] = ~|r_diff;
      end else if (s1_q.cont == MODE_DUAL) begin
         r_diff = {s2_sum[HI_W-1:GAP_W], {MID_W{1'b0}}, s1_q.lo_sum[LANE_W-1:0]};
         r_neg  = {~s2_cout, ~s1_q.c24};
         r_zero = {~|s2_sum[HI_W-1:GAP_W], ~|s1_q.lo_sum[LANE_W-1:0]};
      end
   end

   // ---- output register: holds while the consumer stalls ----
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         diff_q      <= '0;
         neg_q       <= '0;
         zero_q      <= '0;
         cont_q      <= '0;
      end else if (out_adv) begin
         out_valid_q <= s1_valid;
         if (s1_valid) begin
            diff_q <= r_diff;
            neg_q  <= r_neg;
            zero_q <= r_zero;
            cont_q <= s1_q.cont;
         end
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.diff      = diff_q;
   assign bus.neg       = neg_q;
   assign bus.zero      = zero_q;
   assign bus.out_cont  = cont_q;
endmodule
